bcd_scan_ctrl: RTL and testbench

- Time-multiplexing scheduler for the two-digit BCD result (tens/units) produced by the Gray-to-BCD converter.
- Shares one downstream 7-segment decoder between two common-anode digits, with dead-time gaps against ghosting.
- Accepts new BCD values through a valid/ready handshake. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/bcd_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - two-digit BCD display scan scheduler with frame-aligned value commit
// Optional leading-zero blanking of the tens digit: define LZ_BLANK_EN.
module bcd_scan_ctrl #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] an,
    output logic [3:0] digit_bcd,
    output logic       frame_tick,
    output logic       bcd_err
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_UNITS = 3'd1,
        S_GAP1  = 3'd2,
        S_TENS  = 3'd3,
        S_GAP2  = 3'd4
    } state_t;

    localparam int MAX_DWELL = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW        = $clog2(MAX_DWELL + 1);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (BLANK_CYCLES > 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      disp_q, disp_d;
    logic [7:0]      pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic            err_q, err_d;
    logic [1:0]      an_q, an_d;
    logic [3:0]      digit_q, digit_d;
    logic            tick_q, tick_d;
    logic            dwell_done;
    logic            xfer;

    function automatic logic [3:0] shown(input logic [3:0] n);
        return (n > 4'd9) ? 4'hF : n;
    endfunction

    assign in_ready   = !pend_full_q || (state_q == S_LOAD);
    assign xfer       = in_valid && in_ready;
    assign an         = an_q;
    assign digit_bcd  = digit_q;
    assign frame_tick = tick_q;
    assign bcd_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_done = 1'b0;
        unique case (state_q)
            S_LOAD:          dwell_done = 1'b1;
            S_UNITS, S_TENS: dwell_done = (cnt_q == REF_LAST);
            S_GAP1, S_GAP2:  dwell_done = (cnt_q == BLK_LAST);
            default:         dwell_done = 1'b1;
        endcase
        if (dwell_done) begin
            unique case (state_q)
                S_LOAD:  state_d = S_UNITS;
                S_UNITS: state_d = HAS_GAP ? S_GAP1 : S_TENS;
                S_GAP1:  state_d = S_TENS;
                S_TENS:  state_d = HAS_GAP ? S_GAP2 : S_LOAD;
                default: state_d = S_LOAD;
            endcase
        end
        cnt_d = dwell_done ? '0 : cnt_q + CW'(1);
    end

    // Commit happens only in S_LOAD, so a frame never mixes old and new digits.
    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        err_d       = err_q;
        if (state_q == S_LOAD && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
            err_d       = err_q || (pend_q[7:4] > 4'd9) || (pend_q[3:0] > 4'd9);
        end
        if (xfer) begin
            pend_d      = bcd_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q      <= 8'h00;
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
            err_q       <= 1'b0;
            an_q        <= 2'b11;
            digit_q     <= 4'hF;
            tick_q      <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            err_q       <= err_d;
            an_q        <= an_d;
            digit_q     <= digit_d;
            tick_q      <= tick_d;
        end
    end

    // Outputs decode the upcoming state so the registered pins line up with state_q.
    always_comb begin
        an_d    = 2'b11;
        digit_d = 4'hF;
        tick_d  = 1'b0;
        unique case (state_d)
            S_LOAD: tick_d = 1'b1;
            S_UNITS: begin
                an_d    = 2'b10;
                digit_d = shown(disp_d[3:0]);
            end
            S_TENS: begin
`ifdef LZ_BLANK_EN
                if (disp_d[7:4] != 4'd0) begin
                    an_d    = 2'b01;
                    digit_d = shown(disp_d[7:4]);
                end
`else
                an_d    = 2'b01;
                digit_d = shown(disp_d[7:4]);
`endif
            end
            default: begin
                an_d    = 2'b11;
                digit_d = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - self-checking bench for bcd_scan_ctrl
module tb_bcd_scan_ctrl;

    localparam int R  = 4;
    localparam int B  = 1;
    localparam int F  = 1 + 2 * R + 2 * B;
    localparam int F0 = 1 + 2 * R;
    localparam int TENS_MID = 1 + R + B + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bcd_in;
    logic       in_valid;
    logic       in_ready, frame_tick, bcd_err;
    logic [1:0] an;
    logic [3:0] digit_bcd;
    logic [7:0] bcd_in0 = 8'h00;
    logic       in_valid0 = 1'b0;
    logic       ready0, tick0, err0;
    logic [1:0] an0;
    logic [3:0] digit0;

    bcd_scan_ctrl #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) u_dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
        .an(an), .digit_bcd(digit_bcd), .frame_tick(frame_tick), .bcd_err(bcd_err)
    );

    bcd_scan_ctrl #(.REFRESH_CYCLES(R), .BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bcd_in(bcd_in0), .in_valid(in_valid0), .in_ready(ready0),
        .an(an0), .digit_bcd(digit0), .frame_tick(tick0), .bcd_err(err0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tick_count = 0;

    int         pos, pos0;
    logic [7:0] m_disp, m_pend;
    bit         m_full, m_err, m_fresh;

    typedef struct {
        logic [7:0] val;
        logic [3:0] exp_units;
        logic [3:0] exp_tens;
        logic [1:0] exp_tens_an;
        logic       exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] vis(input logic [3:0] n);
        return (n > 4'd9) ? 4'hF : n;
    endfunction

    task automatic check_outputs();
        logic [1:0] e_an;
        logic [3:0] e_dg;
        e_an = 2'b11;
        e_dg = 4'hF;
        if (pos >= 1 && pos <= R) begin
            e_an = 2'b10;
            e_dg = vis(m_disp[3:0]);
        end else if (pos > R + B && pos <= 2 * R + B) begin
`ifdef LZ_BLANK_EN
            if (m_disp[7:4] != 4'd0) begin
                e_an = 2'b01;
                e_dg = vis(m_disp[7:4]);
            end
`else
            e_an = 2'b01;
            e_dg = vis(m_disp[7:4]);
`endif
        end
        chk("an", 8'(an), 8'(e_an));
        chk("digit_bcd", 8'(digit_bcd), 8'(e_dg));
        chk("frame_tick", 8'(frame_tick), 8'(pos == 0 && !m_fresh));
        chk("bcd_err", 8'(bcd_err), 8'(m_err));
        chk("in_ready", 8'(in_ready), 8'(!m_full || pos == 0));
        if (frame_tick) tick_count++;
        chk("nogap_an", 8'(an0), 8'((pos0 == 0) ? 2'b11 : (pos0 <= R) ? 2'b10 : 2'b01));
        chk("nogap_digit", 8'(digit0), 8'((pos0 == 0) ? 4'hF : 4'h0));
        chk("nogap_tick", 8'(tick0), 8'(pos0 == 0 && !m_fresh));
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        bit ready;
        in_valid = v;
        bcd_in   = d;
        #1;
        check_outputs();
        @(posedge clk);
        ready = !m_full || pos == 0;
        if (pos == 0 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
            if (m_pend[7:4] > 4'd9 || m_pend[3:0] > 4'd9) m_err = 1'b1;
        end
        if (v && ready) begin
            m_pend = d;
            m_full = 1'b1;
        end
        pos     = (pos + 1) % F;
        pos0    = (pos0 + 1) % F0;
        m_fresh = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < F && pos != p; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        bcd_in   = 8'h00;
        #1;
        chk("rst_an", 8'(an), 8'h03);
        chk("rst_digit", 8'(digit_bcd), 8'h0F);
        chk("rst_tick", 8'(frame_tick), 8'h00);
        chk("rst_err", 8'(bcd_err), 8'h00);
        chk("rst_ready", 8'(in_ready), 8'h01);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        pos     = 0;
        pos0    = 0;
        m_disp  = 8'h00;
        m_pend  = 8'h00;
        m_full  = 1'b0;
        m_err   = 1'b0;
        m_fresh = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'h12, 4'h2, 4'h1, 2'b01, 1'b0};
`ifdef LZ_BLANK_EN
        vecs[1] = '{8'h07, 4'h7, 4'hF, 2'b11, 1'b0};
`else
        vecs[1] = '{8'h07, 4'h7, 4'h0, 2'b01, 1'b0};
`endif
        vecs[2] = '{8'h3C, 4'hF, 4'h3, 2'b01, 1'b1};
        vecs[3] = '{8'h45, 4'h5, 4'h4, 2'b01, 1'b1};
        vecs[4] = '{8'h90, 4'h0, 4'h9, 2'b01, 1'b1};

        do_reset();

        // Two idle frames: only the second frame start pulses, the reset cycle does not.
        for (int i = 0; i < 2 * F; i++) step(1'b0, 8'h00);
        chk("tick_count_2frames", 8'(tick_count), 8'd1);

        for (int v = 0; v < 5; v++) begin
            wait_pos(2);
            chk("ready_before_send", 8'(in_ready), 8'h01);
            step(1'b1, vecs[v].val);
            chk("ready_after_send", 8'(in_ready), 8'h00);
            wait_pos(0);
            step(1'b0, 8'h00);
            wait_pos(2);
            chk("vec_units_an", 8'(an), 8'h02);
            chk("vec_units_digit", 8'(digit_bcd), 8'(vecs[v].exp_units));
            wait_pos(TENS_MID);
            chk("vec_tens_an", 8'(an), 8'(vecs[v].exp_tens_an));
            chk("vec_tens_digit", 8'(digit_bcd), 8'(vecs[v].exp_tens));
            chk("vec_err", 8'(bcd_err), 8'(vecs[v].exp_err));
        end

        // First value wins while pending is full; the held one lands at S_LOAD.
        wait_pos(2);
        step(1'b1, 8'h07);
        for (int i = 0; i < F && pos != 0; i++) begin
            chk("hold_not_ready", 8'(in_ready), 8'h00);
            step(1'b1, 8'h10);
        end
        chk("ready_at_load", 8'(in_ready), 8'h01);
        step(1'b1, 8'h10);
        wait_pos(2);
        chk("hold_units_07", 8'(digit_bcd), 8'h07);
        wait_pos(0);
        step(1'b0, 8'h00);
        wait_pos(2);
        chk("hold_units_10", 8'(digit_bcd), 8'h00);
        wait_pos(TENS_MID);
        chk("hold_tens_10", 8'(digit_bcd), 8'h01);
        chk("err_sticky", 8'(bcd_err), 8'h01);

        // Reset during the tens window discards a pending value.
        wait_pos(2);
        step(1'b1, 8'h55);
        wait_pos(TENS_MID + 1);
        do_reset();
        chk("err_cleared", 8'(bcd_err), 8'h00);
        wait_pos(2);
        chk("post_rst_units", 8'(digit_bcd), 8'h00);
        wait_pos(TENS_MID);
        chk("post_rst_tens", 8'(digit_bcd), 8'h00);

        for (int i = 0; i < 500; i++) step($urandom_range(0, 2) == 0, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
